// File: rtl/cgra_pe_tile.sv
// cgra_pe_tile: single 16-bit CGRA processing element tile.
// Holds its own configuration (connection boxes, switch boxes, PE op/constant),
// written over a 32-bit address/data bus matched against TILE_ID.
// Optional feature macro: PE_MUL_EN (enables the 16x16 multiplier for opcode 7;
// when undefined, opcode 7 yields 16'h0000 and no multiplier is built).
module cgra_pe_tile #(
    parameter logic [15:0] TILE_ID = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] config_addr,
    input  logic [31:0] config_data,
    input  logic [15:0] in_s0,
    input  logic [15:0] in_s1,
    input  logic [15:0] in_s2,
    input  logic [15:0] in_s3,
    output logic [15:0] out_s0,
    output logic [15:0] out_s1,
    output logic [15:0] out_s2,
    output logic [15:0] out_s3
);

    localparam int unsigned DW      = 16;
    localparam int unsigned SB_W    = 3;
    localparam int unsigned CB_W    = 2;
    localparam int unsigned OP_W    = 4;

    localparam logic [7:0] FEAT_CB_A = 8'h00;
    localparam logic [7:0] FEAT_CB_B = 8'h01;
    localparam logic [7:0] FEAT_SB0  = 8'h02;
    localparam logic [7:0] FEAT_SB1  = 8'h03;
    localparam logic [7:0] FEAT_SB2  = 8'h04;
    localparam logic [7:0] FEAT_SB3  = 8'h05;
    localparam logic [7:0] FEAT_PE   = 8'hFF;

    localparam logic [OP_W-1:0] OP_ADD  = 4'd0;
    localparam logic [OP_W-1:0] OP_SUB  = 4'd1;
    localparam logic [OP_W-1:0] OP_AND  = 4'd2;
    localparam logic [OP_W-1:0] OP_OR   = 4'd3;
    localparam logic [OP_W-1:0] OP_XOR  = 4'd4;
    localparam logic [OP_W-1:0] OP_SHL  = 4'd5;
    localparam logic [OP_W-1:0] OP_SHR  = 4'd6;
    localparam logic [OP_W-1:0] OP_MUL  = 4'd7;
    localparam logic [OP_W-1:0] OP_MAX  = 4'd8;
    localparam logic [OP_W-1:0] OP_MIN  = 4'd9;
    localparam logic [OP_W-1:0] OP_PASS = 4'd10;

    // Internal side-input nets; these mirror the ports and are the force points.
    logic [DW-1:0] wire_0_0_BUS16_S0_T4;
    logic [DW-1:0] wire_0_0_BUS16_S1_T4;
    logic [DW-1:0] wire_0_0_BUS16_S2_T4;
    logic [DW-1:0] wire_0_0_BUS16_S3_T4;

    assign wire_0_0_BUS16_S0_T4 = in_s0;
    assign wire_0_0_BUS16_S1_T4 = in_s1;
    assign wire_0_0_BUS16_S2_T4 = in_s2;
    assign wire_0_0_BUS16_S3_T4 = in_s3;

    // Configuration state
    logic [CB_W-1:0] cb_a_sel;
    logic [CB_W-1:0] cb_b_sel;
    logic [SB_W-1:0] sb0_sel;
    logic [SB_W-1:0] sb1_sel;
    logic [SB_W-1:0] sb2_sel;
    logic [SB_W-1:0] sb3_sel;
    logic [OP_W-1:0] pe_op;
    logic            pe_reg_en;
    logic            pe_b_const;
    logic [DW-1:0]   pe_const;
    logic [DW-1:0]   pe_q;

    logic            cfg_hit;
    logic [7:0]      cfg_feat;
    logic [7:0]      cfg_reg;
    logic [DW-1:0]   op_a;
    logic [DW-1:0]   op_b;
    logic [DW-1:0]   alu;
    logic [DW-1:0]   pe_result;
    logic [DW-1:0]   unused_cfg_bits;

    assign cfg_hit         = (config_addr[15:0] == TILE_ID);
    assign cfg_feat        = config_addr[23:16];
    assign cfg_reg         = config_addr[31:24];
    assign unused_cfg_bits = config_data[31:16];

    // Configuration register writes; any edge with a tile-id match is a write
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cb_a_sel   <= '0;
            cb_b_sel   <= '0;
            sb0_sel    <= '0;
            sb1_sel    <= '0;
            sb2_sel    <= '0;
            sb3_sel    <= '0;
            pe_op      <= '0;
            pe_reg_en  <= 1'b0;
            pe_b_const <= 1'b0;
            pe_const   <= '0;
        end else if (cfg_hit) begin
            case (cfg_feat)
                FEAT_CB_A: if (cfg_reg == 8'd0) cb_a_sel <= config_data[CB_W-1:0];
                FEAT_CB_B: if (cfg_reg == 8'd0) cb_b_sel <= config_data[CB_W-1:0];
                FEAT_SB0:  if (cfg_reg == 8'd0) sb0_sel  <= config_data[SB_W-1:0];
                FEAT_SB1:  if (cfg_reg == 8'd0) sb1_sel  <= config_data[SB_W-1:0];
                FEAT_SB2:  if (cfg_reg == 8'd0) sb2_sel  <= config_data[SB_W-1:0];
                FEAT_SB3:  if (cfg_reg == 8'd0) sb3_sel  <= config_data[SB_W-1:0];
                FEAT_PE: begin
                    if (cfg_reg == 8'd0) begin
                        pe_op      <= config_data[OP_W-1:0];
                        pe_reg_en  <= config_data[4];
                        pe_b_const <= config_data[5];
                    end else if (cfg_reg == 8'd1) begin
                        pe_const   <= config_data[DW-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    // Connection boxes: pick ALU operands from the side inputs
    always_comb begin
        op_a = '0;
        op_b = '0;
        case (cb_a_sel)
            2'd0:    op_a = wire_0_0_BUS16_S0_T4;
            2'd1:    op_a = wire_0_0_BUS16_S1_T4;
            2'd2:    op_a = wire_0_0_BUS16_S2_T4;
            default: op_a = wire_0_0_BUS16_S3_T4;
        endcase
        if (pe_b_const) begin
            op_b = pe_const;
        end else begin
            case (cb_b_sel)
                2'd0:    op_b = wire_0_0_BUS16_S0_T4;
                2'd1:    op_b = wire_0_0_BUS16_S1_T4;
                2'd2:    op_b = wire_0_0_BUS16_S2_T4;
                default: op_b = wire_0_0_BUS16_S3_T4;
            endcase
        end
    end

    // ALU: unsigned 16-bit, all results truncated to 16 bits
    always_comb begin
        alu = '0;
        case (pe_op)
            OP_ADD:  alu = op_a + op_b;
            OP_SUB:  alu = op_a - op_b;
            OP_AND:  alu = op_a & op_b;
            OP_OR:   alu = op_a | op_b;
            OP_XOR:  alu = op_a ^ op_b;
            OP_SHL:  alu = op_a << op_b[3:0];
            OP_SHR:  alu = op_a >> op_b[3:0];
`ifdef PE_MUL_EN
            OP_MUL:  alu = op_a * op_b;
`else
            OP_MUL:  alu = '0;
`endif
            OP_MAX:  alu = (op_a > op_b) ? op_a : op_b;
            OP_MIN:  alu = (op_a < op_b) ? op_a : op_b;
            OP_PASS: alu = op_a;
            default: alu = '0;
        endcase
    end

    // PE output register loads every cycle regardless of the enable
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pe_q <= '0;
        end else begin
            pe_q <= alu;
        end
    end

    assign pe_result = pe_reg_en ? pe_q : alu;

    function automatic logic [DW-1:0] sb_mux(
        input logic [SB_W-1:0] sel,
        input logic [DW-1:0]   i0,
        input logic [DW-1:0]   i1,
        input logic [DW-1:0]   i2,
        input logic [DW-1:0]   i3,
        input logic [DW-1:0]   pe
    );
        logic [DW-1:0] r;
        r = '0;
        case (sel)
            3'd1:    r = i0;
            3'd2:    r = i1;
            3'd3:    r = i2;
            3'd4:    r = i3;
            3'd5:    r = pe;
            default: r = '0;
        endcase
        return r;
    endfunction

    // Switch boxes: drive side outputs from inputs or the PE result
    always_comb begin
        out_s0 = sb_mux(sb0_sel, wire_0_0_BUS16_S0_T4, wire_0_0_BUS16_S1_T4,
                        wire_0_0_BUS16_S2_T4, wire_0_0_BUS16_S3_T4, pe_result);
        out_s1 = sb_mux(sb1_sel, wire_0_0_BUS16_S0_T4, wire_0_0_BUS16_S1_T4,
                        wire_0_0_BUS16_S2_T4, wire_0_0_BUS16_S3_T4, pe_result);
        out_s2 = sb_mux(sb2_sel, wire_0_0_BUS16_S0_T4, wire_0_0_BUS16_S1_T4,
                        wire_0_0_BUS16_S2_T4, wire_0_0_BUS16_S3_T4, pe_result);
        out_s3 = sb_mux(sb3_sel, wire_0_0_BUS16_S0_T4, wire_0_0_BUS16_S1_T4,
                        wire_0_0_BUS16_S2_T4, wire_0_0_BUS16_S3_T4, pe_result);
    end

endmodule

// File: tb/tb_cgra_pe_tile.sv
// Bench for cgra_pe_tile: directed plan scenarios plus randomized config/data
// traffic, checked every cycle against a behavioural model of the tile.
`timescale 1ns/1ps
module tb_cgra_pe_tile;

    localparam logic [31:0] IDLE_ADDR = 32'h0000_FFFF;  // tile id FFFF: never a hit

    logic        clk;
    logic        reset;
    logic [31:0] config_addr;
    logic [31:0] config_data;
    logic [15:0] tin [4];
    logic [15:0] out_s0, out_s1, out_s2, out_s3;

    int vectors;
    int miscompares;

    // Behavioural model state
    int unsigned m_cb [2];
    int unsigned m_sb [4];
    int unsigned m_op, m_reg_en, m_bconst, m_const, m_q;

    cgra_pe_tile #(.TILE_ID(16'h0000)) dut (
        .clk        (clk),
        .reset      (reset),
        .config_addr(config_addr),
        .config_data(config_data),
        .in_s0      (tin[0]),
        .in_s1      (tin[1]),
        .in_s2      (tin[2]),
        .in_s3      (tin[3]),
        .out_s0     (out_s0),
        .out_s1     (out_s1),
        .out_s2     (out_s2),
        .out_s3     (out_s3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int unsigned ref_alu(input int unsigned op, input int unsigned a,
                                            input int unsigned b);
        int unsigned r;
        case (op)
            0: r = a + b;
            1: r = a - b;
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = a << (b % 16);
            6: r = a >> (b % 16);
`ifdef PE_MUL_EN
            7: r = a * b;
`else
            7: r = 0;
`endif
            8: r = (a > b) ? a : b;
            9: r = (a < b) ? a : b;
            10: r = a;
            default: r = 0;
        endcase
        return r % 65536;
    endfunction

    function automatic int unsigned model_alu();
        int unsigned b;
        b = m_bconst ? m_const : int'(tin[m_cb[1]]);
        return ref_alu(m_op, int'(tin[m_cb[0]]), b);
    endfunction

    function automatic logic [15:0] model_out(input int k);
        int unsigned sel;
        int unsigned pe;
        sel = m_sb[k];
        pe  = m_reg_en ? m_q : model_alu();
        if (sel >= 1 && sel <= 4) return tin[sel-1];
        if (sel == 5) return 16'(pe);
        return 16'h0000;
    endfunction

    function automatic void model_reset();
        m_cb[0] = 0; m_cb[1] = 0;
        for (int k = 0; k < 4; k++) m_sb[k] = 0;
        m_op = 0; m_reg_en = 0; m_bconst = 0; m_const = 0; m_q = 0;
    endfunction

    function automatic void model_write(input logic [31:0] a, input logic [31:0] d);
        int unsigned feat, rg;
        if (a[15:0] != 16'h0000) return;
        feat = int'(a[23:16]);
        rg   = int'(a[31:24]);
        if (feat <= 1 && rg == 0) m_cb[feat] = d % 4;
        else if (feat >= 2 && feat <= 5 && rg == 0) m_sb[feat-2] = d % 8;
        else if (feat == 255 && rg == 0) begin
            m_op     = d % 16;
            m_reg_en = (d / 16) % 2;
            m_bconst = (d / 32) % 2;
        end else if (feat == 255 && rg == 1) m_const = d % 65536;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic compare_all();
        check("out_s0", out_s0, model_out(0));
        check("out_s1", out_s1, model_out(1));
        check("out_s2", out_s2, model_out(2));
        check("out_s3", out_s3, model_out(3));
    endtask

    // Drive one cycle's inputs, settle, compare against the model
    task automatic apply(input logic [31:0] a, input logic [31:0] d,
                         input logic [15:0] i0, input logic [15:0] i1,
                         input logic [15:0] i2, input logic [15:0] i3);
        config_addr = a;
        config_data = d;
        tin[0] = i0; tin[1] = i1; tin[2] = i2; tin[3] = i3;
        #3;
        compare_all();
    endtask

    // Clock edge: register captures old-config ALU, then the write lands
    task automatic edge_step();
        int unsigned nq;
        @(posedge clk);
        if (!reset) begin
            nq  = model_alu();
            m_q = nq;
            model_write(config_addr, config_data);
        end
        #1;
    endtask

    task automatic write_cfg(input logic [31:0] a, input logic [31:0] d);
        apply(a, d, tin[0], tin[1], tin[2], tin[3]);
        edge_step();
    endtask

    initial begin
        logic [31:0] ra, rd;
        int unsigned feat_pick;
        vectors = 0;
        miscompares = 0;
        model_reset();
        reset = 1'b1;
        config_addr = IDLE_ADDR;
        config_data = 32'h0;
        for (int k = 0; k < 4; k++) tin[k] = 16'(k * 16'h1111 + 16'h0101);
        #1;
        check("reset_out_s0", out_s0, 16'h0000);
        check("reset_out_s3", out_s3, 16'h0000);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // No writes yet: all outputs zero for random inputs
        for (int c = 0; c < 4; c++) begin
            apply(IDLE_ADDR, 32'h0, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
            check("idle_zero_s0", out_s0, 16'h0000);
            check("idle_zero_s2", out_s2, 16'h0000);
            edge_step();
        end

        // SB0 pass-through of in_s1 driven with a 4-bit counter
        write_cfg(32'h0002_0000, 32'd2);
        for (int c = 0; c < 16; c++) begin
            apply(IDLE_ADDR, 32'h0, 16'h0, 16'(c), 16'h0, 16'h0);
            check("sb0_counter", out_s0, 16'(c));
            edge_step();
        end

        // Combinational add with wrap
        write_cfg(32'h0000_0000, 32'd0);
        write_cfg(32'h0001_0000, 32'd1);
        write_cfg(32'h00FF_0000, 32'h00);
        write_cfg(32'h0005_0000, 32'd5);
        apply(IDLE_ADDR, 32'h0, 16'hFFFF, 16'h0002, 16'h0, 16'h0);
        check("add_wrap", out_s3, 16'h0001);
        edge_step();

        // Registered add with constant B = 5
        write_cfg(32'h00FF_0000, 32'h30);
        write_cfg(32'h01FF_0000, 32'h5);
        apply(IDLE_ADDR, 32'h0, 16'd3, 16'h0, 16'h0, 16'h0);
        edge_step();
        apply(IDLE_ADDR, 32'h0, 16'd10, 16'h0, 16'h0, 16'h0);
        check("reg_add_8", out_s3, 16'd8);
        edge_step();
        apply(IDLE_ADDR, 32'h0, 16'd10, 16'h0, 16'h0, 16'h0);
        check("reg_add_15", out_s3, 16'd15);
        edge_step();

        // Multiply, combinational, B from CB_B (in_s1)
        write_cfg(32'h00FF_0000, 32'h07);
        apply(IDLE_ADDR, 32'h0, 16'h0100, 16'h0100, 16'h0, 16'h0);
        check("mul_0100", out_s3, 16'h0000);
        edge_step();
        apply(IDLE_ADDR, 32'h0, 16'd300, 16'd200, 16'h0, 16'h0);
`ifdef PE_MUL_EN
        check("mul_300x200", out_s3, 16'hEA60);
`else
        check("mul_300x200", out_s3, 16'h0000);
`endif
        edge_step();

        // Write to another tile id must not change opcode (would become add)
        write_cfg(32'h00FF_0001, 32'h00);
        apply(IDLE_ADDR, 32'h0, 16'd3, 16'd5, 16'h0, 16'h0);
`ifdef PE_MUL_EN
        check("foreign_tile", out_s3, 16'd15);
`else
        check("foreign_tile", out_s3, 16'd0);
`endif
        edge_step();

        // Randomized configuration and data traffic
        for (int c = 0; c < 400; c++) begin
            feat_pick = $urandom_range(0, 9);
            case (feat_pick)
                0, 1, 2, 3, 4, 5: ra[23:16] = 8'(feat_pick);
                6, 7:             ra[23:16] = 8'hFF;
                default:          ra[23:16] = 8'($urandom);
            endcase
            ra[31:24] = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(0, 3))
                      : ((ra[23:16] == 8'hFF) ? 8'($urandom_range(0, 1)) : 8'h00);
            ra[15:0]  = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'h0000;
            rd = $urandom;
            if ($urandom_range(0, 2) == 0) rd[2:0] = 3'd5;
            apply(ra, rd, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
            edge_step();
        end

        // Mid-stream reset: outputs must drop to zero without a clock edge
        write_cfg(32'h0002_0000, 32'd1);
        apply(32'h0003_0000, 32'd5, 16'hA5A5, 16'h1234, 16'h0, 16'h0);
        check("pre_reset_s0", out_s0, 16'hA5A5);
        reset = 1'b1;
        #1;
        model_reset();
        check("async_reset_s0", out_s0, 16'h0000);
        check("async_reset_s1", out_s1, 16'h0000);
        check("async_reset_s2", out_s2, 16'h0000);
        check("async_reset_s3", out_s3, 16'h0000);
        edge_step();
        reset = 1'b0;
        for (int c = 0; c < 60; c++) begin
            ra = {8'h00, ($urandom_range(0, 1) == 0) ? 8'hFF : 8'($urandom_range(0, 5)), 16'h0000};
            if ($urandom_range(0, 3) == 0) ra = IDLE_ADDR;
            apply(ra, $urandom, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
            edge_step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
